// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS control FSM (master)
// and the datapath (slave).
interface mips_multicycle_ctrl_if #(
    parameter int unsigned ALUC_W = 4
);
    logic [5:0]        op;
    logic [5:0]        funct;
    logic              zero;
    logic              mem_ready;
    logic              pcen;
    logic              memwrite;
    logic              irwrite;
    logic              regwrite;
    logic              alusrca;
    logic [1:0]        alusrcb;
    logic              iord;
    logic              memtoreg;
    logic              regdst;
    logic [1:0]        pcsrc;
    logic [ALUC_W-1:0] alucontrol;
    logic              instr_done;
    logic              illegal_op;

    modport master (
        input  op, funct, zero, mem_ready,
        output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, alucontrol, instr_done, illegal_op
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, alucontrol, instr_done, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// Optional `MIPS_MC_BNE_EN adds bne (opcode 000101) through the BRANCH state.
module mips_multicycle_ctrl #(
    parameter int unsigned ALUC_W       = 4,
    parameter bit          USE_MEMREADY = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    state_t     state, state_n;
    logic       rdy;
    logic       br_take;
    logic [3:0] aluc;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord;
    logic       memtoreg, regdst, instr_done, illegal_op;
    logic [1:0] alusrcb, pcsrc;

    assign rdy = USE_MEMREADY ? bus.mem_ready : 1'b1;

`ifdef MIPS_MC_BNE_EN
    assign br_take = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
`else
    assign br_take = bus.zero;
`endif

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            6'b100111: funct_alu = ALU_NOR;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    // Next state plus Moore decode; FETCH/MEMWR/BRANCH qualify strobes with inputs.
    always_comb begin
        state_n    = state;
        pcen       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        pcsrc      = 2'b00;
        aluc       = ALU_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = rdy;
                pcen    = rdy;
                if (rdy) state_n = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_EXEC;
                    OP_BEQ:       state_n = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:       state_n = S_BRANCH;
`endif
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JUMP;
                    default: begin
                        state_n    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_n = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (rdy) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = rdy;
                if (rdy) state_n = S_FETCH;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluc    = funct_alu(bus.funct);
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_n    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluc       = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = br_take;
                instr_done = 1'b1;
                state_n    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_n = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_n    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                instr_done = 1'b1;
                state_n    = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

    assign bus.pcen       = pcen;
    assign bus.memwrite   = memwrite;
    assign bus.irwrite    = irwrite;
    assign bus.regwrite   = regwrite;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.iord       = iord;
    assign bus.memtoreg   = memtoreg;
    assign bus.regdst     = regdst;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = ALUC_W'(aluc);
    assign bus.instr_done = instr_done;
    assign bus.illegal_op = illegal_op;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle vector bench for mips_multicycle_ctrl; expected outputs per
// cycle are queued when driven and compared once the outputs settle.
module tb_mips_multicycle_ctrl;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic       pcen, memwrite, irwrite, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic       iord, memtoreg, regdst;
        logic [1:0] pcsrc;
        logic [3:0] aluc;
        logic       done, ill;
    } outs_t;

    typedef struct {
        logic       rst, chk, rdy, zero;
        logic [5:0] op, funct;
        outs_t      exp;
        string      nm;
    } vec_t;

    typedef struct {
        logic [5:0] f;
        logic [3:0] c;
    } rt_t;

    logic  clk = 1'b0;
    logic  reset;
    vec_t  vq[$];
    vec_t  sb[$];
    int    total = 0;
    int    bad = 0;

    mips_multicycle_ctrl_if #(.ALUC_W(4)) bus();

    mips_multicycle_ctrl #(.ALUC_W(4), .USE_MEMREADY(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic outs_t o_idle();
        outs_t r = '0;
        r.aluc = 4'b0010;
        return r;
    endfunction
    function automatic outs_t o_fetch(input logic r);
        outs_t x = o_idle();
        x.alusrcb = 2'b01; x.irwrite = r; x.pcen = r;
        return x;
    endfunction
    function automatic outs_t o_decode(input logic ill);
        outs_t x = o_idle();
        x.alusrcb = 2'b11; x.ill = ill;
        return x;
    endfunction
    function automatic outs_t o_memadr();
        outs_t x = o_idle();
        x.alusrca = 1'b1; x.alusrcb = 2'b10;
        return x;
    endfunction
    function automatic outs_t o_memrd();
        outs_t x = o_idle();
        x.iord = 1'b1;
        return x;
    endfunction
    function automatic outs_t o_memwb();
        outs_t x = o_idle();
        x.memtoreg = 1'b1; x.regwrite = 1'b1; x.done = 1'b1;
        return x;
    endfunction
    function automatic outs_t o_memwr(input logic r);
        outs_t x = o_idle();
        x.iord = 1'b1; x.memwrite = 1'b1; x.done = r;
        return x;
    endfunction
    function automatic outs_t o_exec(input logic [3:0] c);
        outs_t x = o_idle();
        x.alusrca = 1'b1; x.aluc = c;
        return x;
    endfunction
    function automatic outs_t o_aluwb();
        outs_t x = o_idle();
        x.regdst = 1'b1; x.regwrite = 1'b1; x.done = 1'b1;
        return x;
    endfunction
    function automatic outs_t o_branch(input logic take);
        outs_t x = o_idle();
        x.alusrca = 1'b1; x.aluc = 4'b0110; x.pcsrc = 2'b01;
        x.pcen = take; x.done = 1'b1;
        return x;
    endfunction
    function automatic outs_t o_addiwb();
        outs_t x = o_idle();
        x.regwrite = 1'b1; x.done = 1'b1;
        return x;
    endfunction
    function automatic outs_t o_jump();
        outs_t x = o_idle();
        x.pcsrc = 2'b10; x.pcen = 1'b1; x.done = 1'b1;
        return x;
    endfunction

    task automatic add(input logic rst, input logic chk, input logic rdy,
                       input logic [5:0] op, input logic [5:0] funct,
                       input logic zero, input outs_t exp, input string nm);
        vec_t v;
        v.rst = rst; v.chk = chk; v.rdy = rdy; v.zero = zero;
        v.op = op; v.funct = funct; v.exp = exp; v.nm = nm;
        vq.push_back(v);
    endtask

    function automatic outs_t sample();
        outs_t a;
        a.pcen = bus.pcen; a.memwrite = bus.memwrite; a.irwrite = bus.irwrite;
        a.regwrite = bus.regwrite; a.alusrca = bus.alusrca; a.alusrcb = bus.alusrcb;
        a.iord = bus.iord; a.memtoreg = bus.memtoreg; a.regdst = bus.regdst;
        a.pcsrc = bus.pcsrc; a.aluc = bus.alucontrol; a.done = bus.instr_done;
        a.ill = bus.illegal_op;
        return a;
    endfunction

    task automatic check(input outs_t exp, input string nm);
        outs_t act;
        act = sample();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%05h want=%05h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rdy, input logic [5:0] op,
                        input logic [5:0] funct, input logic zero);
        @(negedge clk);
        reset         = rst;
        bus.mem_ready = rdy;
        bus.op        = op;
        bus.funct     = funct;
        bus.zero      = zero;
        #1;
    endtask

    initial begin
        rt_t   rt[7];
        vec_t  e;

        rt[0] = '{6'b100000, 4'b0010};
        rt[1] = '{6'b100010, 4'b0110};
        rt[2] = '{6'b100100, 4'b0000};
        rt[3] = '{6'b100101, 4'b0001};
        rt[4] = '{6'b101010, 4'b0111};
        rt[5] = '{6'b100111, 4'b1100};
        rt[6] = '{6'b111000, 4'b0010};

        reset = 1'b1;
        bus.mem_ready = 1'b0; bus.op = '0; bus.funct = '0; bus.zero = 1'b0;

        // Reset two cycles, then lw with memory always ready: 5 cycles.
        add(1, 0, 0, OP_LW, 0, 0, o_idle(),     "rst0");
        add(1, 1, 0, OP_LW, 0, 0, o_fetch(0),   "rst_state");
        add(0, 1, 1, OP_LW, 0, 0, o_fetch(1),   "lw_fetch");
        add(0, 1, 1, OP_LW, 0, 0, o_decode(0),  "lw_decode");
        add(0, 1, 1, OP_LW, 0, 0, o_memadr(),   "lw_memadr");
        add(0, 1, 1, OP_LW, 0, 0, o_memrd(),    "lw_memrd");
        add(0, 1, 1, OP_LW, 0, 0, o_memwb(),    "lw_memwb");

        // Fetch stall 3 cycles then an SLT R-type.
        for (int k = 0; k < 3; k++)
            add(0, 1, 0, OP_R, 6'b101010, 0, o_fetch(0), "stall_fetch");
        add(0, 1, 1, OP_R, 6'b101010, 0, o_fetch(1),        "stall_release");
        add(0, 1, 1, OP_R, 6'b101010, 0, o_decode(0),       "slt_decode");
        add(0, 1, 1, OP_R, 6'b101010, 0, o_exec(4'b0111),   "slt_exec");
        add(0, 1, 1, OP_R, 6'b101010, 0, o_aluwb(),         "slt_aluwb");

        // Full funct table, including an unknown funct defaulting to ADD.
        for (int k = 0; k < 7; k++) begin
            add(0, 1, 1, OP_R, rt[k].f, 0, o_fetch(1),       "rt_fetch");
            add(0, 1, 1, OP_R, rt[k].f, 0, o_decode(0),      "rt_decode");
            add(0, 1, 1, OP_R, rt[k].f, 0, o_exec(rt[k].c),  "rt_exec");
            add(0, 1, 1, OP_R, rt[k].f, 0, o_aluwb(),        "rt_aluwb");
        end

        // beq taken and not taken.
        for (int z = 1; z >= 0; z--) begin
            add(0, 1, 1, OP_BEQ, 0, 1'(z), o_fetch(1),         "beq_fetch");
            add(0, 1, 1, OP_BEQ, 0, 1'(z), o_decode(0),        "beq_decode");
            add(0, 1, 1, OP_BEQ, 0, 1'(z), o_branch(1'(z)),    "beq_branch");
        end

        add(0, 1, 1, OP_ADDI, 0, 0, o_fetch(1),  "addi_fetch");
        add(0, 1, 1, OP_ADDI, 0, 0, o_decode(0), "addi_decode");
        add(0, 1, 1, OP_ADDI, 0, 0, o_memadr(),  "addi_ex");
        add(0, 1, 1, OP_ADDI, 0, 0, o_addiwb(),  "addi_wb");

        add(0, 1, 1, OP_J, 0, 0, o_fetch(1),  "j_fetch");
        add(0, 1, 1, OP_J, 0, 0, o_decode(0), "j_decode");
        add(0, 1, 1, OP_J, 0, 0, o_jump(),    "j_jump");

        // Illegal opcode: pulse in DECODE, back to FETCH (held by rdy=0).
        add(0, 1, 1, OP_BAD, 0, 0, o_fetch(1),  "ill_fetch");
        add(0, 1, 1, OP_BAD, 0, 0, o_decode(1), "ill_decode");
        add(0, 1, 0, OP_BAD, 0, 0, o_fetch(0),  "ill_refetch");

        add(0, 1, 1, OP_BNE, 0, 0, o_fetch(1),  "bne_fetch");
`ifdef MIPS_MC_BNE_EN
        add(0, 1, 1, OP_BNE, 0, 0, o_decode(0), "bne_decode");
        add(0, 1, 1, OP_BNE, 0, 0, o_branch(1), "bne_branch");
`else
        add(0, 1, 1, OP_BNE, 0, 0, o_decode(1), "bne_illegal");
        add(0, 1, 0, OP_BNE, 0, 0, o_fetch(0),  "bne_refetch");
        add(0, 1, 1, OP_BNE, 0, 0, o_fetch(1),  "bne_fetch2");
        add(0, 1, 1, OP_J,   0, 0, o_decode(0), "j2_decode");
        add(0, 1, 1, OP_J,   0, 0, o_jump(),    "j2_jump");
`endif

        // lw with two MEMRD wait cycles: latency grows by 2.
        add(0, 1, 1, OP_LW, 0, 0, o_fetch(1),  "lws_fetch");
        add(0, 1, 1, OP_LW, 0, 0, o_decode(0), "lws_decode");
        add(0, 1, 0, OP_LW, 0, 0, o_memadr(),  "lws_memadr");
        add(0, 1, 0, OP_LW, 0, 0, o_memrd(),   "lws_wait");
        add(0, 1, 0, OP_LW, 0, 0, o_memrd(),   "lws_wait");
        add(0, 1, 1, OP_LW, 0, 0, o_memrd(),   "lws_memrd");
        add(0, 1, 1, OP_LW, 0, 0, o_memwb(),   "lws_memwb");

        // sw stalled in MEMWR, reset mid-wait.
        add(0, 1, 1, OP_SW, 0, 0, o_fetch(1),  "swr_fetch");
        add(0, 1, 1, OP_SW, 0, 0, o_decode(0), "swr_decode");
        add(0, 1, 0, OP_SW, 0, 0, o_memadr(),  "swr_memadr");
        add(0, 1, 0, OP_SW, 0, 0, o_memwr(0),  "swr_wait");
        add(1, 1, 0, OP_SW, 0, 0, o_memwr(0),  "swr_wait_rst");
        add(0, 1, 0, OP_SW, 0, 0, o_fetch(0),  "swr_after_rst");

        // sw with memory ready: 4 cycles.
        add(0, 1, 1, OP_SW, 0, 0, o_fetch(1),  "sw_fetch");
        add(0, 1, 1, OP_SW, 0, 0, o_decode(0), "sw_decode");
        add(0, 1, 1, OP_SW, 0, 0, o_memadr(),  "sw_memadr");
        add(0, 1, 1, OP_SW, 0, 0, o_memwr(1),  "sw_memwr");
        add(0, 1, 0, OP_SW, 0, 0, o_fetch(0),  "sw_refetch");

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset         = vq[i].rst;
            bus.mem_ready = vq[i].rdy;
            bus.op        = vq[i].op;
            bus.funct     = vq[i].funct;
            bus.zero      = vq[i].zero;
            if (vq[i].chk) sb.push_back(vq[i]);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check(e.exp, e.nm);
            end
        end

        // Directed reset-state check: two reset cycles, then FETCH with mem_ready low.
        step(1, 0, OP_LW, 0, 0);
        step(1, 0, OP_LW, 0, 0);
        check(o_fetch(0), "reset_state");

        // Directed expired-wait check: MEMRD holds 3 cycles, then completes.
        step(0, 1, OP_LW, 0, 0);
        step(0, 1, OP_LW, 0, 0);
        step(0, 0, OP_LW, 0, 0);
        step(0, 0, OP_LW, 0, 0);
        step(0, 0, OP_LW, 0, 0);
        step(0, 0, OP_LW, 0, 0);
        step(0, 1, OP_LW, 0, 0);
        check(o_memrd(), "wait_ready_memrd");
        step(0, 0, OP_LW, 0, 0);
        check(o_memwb(), "wait_expired_memwb");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
